pwm_peripheral: RTL and testbench
=================================

// Module: pwm_peripheral
// PURPOSE
//   Consumes the control registers written over SPI (output enables, PWM enables, duty cycle)
//   and drives the 16 chip outputs. Each output is forced low, held static high, or driven by
//   one shared 8-bit PWM waveform. Sits directly downstream of the SPI register block.
//   The duty cycle is double-buffered, so a mid-period SPI write never produces a runt pulse.
// PARAMETERS
//   CLK_DIV   13   clk cycles per PWM count step; at 10 MHz clk the period is 13*256 clk (~3.0 kHz)
// PORTS
//   clk              in   1   system clock; all logic is on its rising edge
//   rst_n            in   1   asynchronous, active-low reset
//   en_reg_out_7_0   in   8   output enable, out[7:0]
//   en_reg_out_15_8  in   8   output enable, out[15:8]
//   en_reg_pwm_7_0   in   8   PWM-mode select, out[7:0]
//   en_reg_pwm_15_8  in   8   PWM-mode select, out[15:8]
//   pwm_duty_cycle   in   8   requested duty: 0x00 = 0 %, 0xFF = 100 %
//   out              out  16  chip outputs, registered
//   period_start     out  1   one-clk pulse in the cycle pwm_cnt wraps 255->0 (registered)
// BEHAVIOUR
//   Reset (async on rst_n low) and its state on release:
//     - div_cnt=0, pwm_cnt=0, duty_q=0, out=16'h0000, period_start=0.
//     - Reset mid-period aborts immediately; counting restarts from 0 on release.
//   Prescaler:
//     - div_cnt counts 0..CLK_DIV-1, then wraps to 0.
//     - tick = (div_cnt==CLK_DIV-1). CLK_DIV=1 gives tick every clk.
//     - div_cnt width = $clog2(CLK_DIV), minimum 1 bit.
//   PWM counter:
//     - On tick, pwm_cnt (8-bit) increments; 255 wraps to 0 (natural overflow). No stall state.
//   Duty shadow:
//     - On tick && pwm_cnt==255, duty_q <= pwm_duty_cycle and period_start <= 1.
//       Otherwise period_start <= 0.
//     - duty_q is never loaded at any other time. Changes to pwm_duty_cycle inside a period
//       are ignored; the value sampled at the boundary wins.
//     - The first period after reset runs with duty_q=0.
//   Waveform (combinational):
//     - pwm_level = (duty_q==8'hFF) ? 1 : (pwm_cnt < duty_q), unsigned 8-bit compare.
//     - duty 0: level is always 0.
//     - duty 0xFF: level is always 1, with no one-count low glitch.
//     - duty N (1..254): level is high for N*CLK_DIV clk of every 256*CLK_DIV clk.
//   Output mux, per bit i (en_out = {15_8,7_0}, en_pwm likewise):
//     - en_out[i]=0 -> out[i] <= 0, regardless of en_pwm[i].
//     - en_out[i]=1, en_pwm[i]=0 -> out[i] <= 1 (static high).
//     - en_out[i]=1, en_pwm[i]=1 -> out[i] <= pwm_level.
//   Latency and ordering:
//     - Enable changes appear on out one clk later; they are not synchronised to the period.
//     - out follows pwm_cnt/duty_q changes by one clk.
//     - A duty load and a counter wrap in the same cycle: the new duty_q governs pwm_cnt=0.
//   Input timing:
//     - All inputs are clk-domain registers; no synchronisers here.
// TESTING
//   1. Reset: hold rst_n=0 with all enables 0xFF and duty 0x80
//      -> out=0000, period_start=0. Also assert rst_n mid-period
//      -> out clears within the same cycle, asynchronously.
//   2. Static: en_out=16'hFFFF, en_pwm=0
//      -> out=FFFF one clk after the write. en_out=16'h00F0 -> out=00F0.
//   3. Duty sweep, all bits PWM, CLK_DIV=13:
//      - duty 0x00 -> always 0.
//      - duty 0xFF -> always 1 after the first boundary.
//      - duty 0x80 -> 1664 clk high / 3328 clk period.
//      - duty 0x01 -> 13 clk high.
//   4. Mid-period write: duty 0x40 running, write 0xC0 at pwm_cnt=0x20
//      -> current period keeps 0x40 timing; next period (after period_start) has 0xC0 high width.
//   5. Mixed mux: en_out=16'h0F0F, en_pwm=16'h0303, duty 0x80
//      -> bits 0,1,8,9 toggle in phase; bits 2,3,10,11 stay 1; all other bits stay 0.
//      Also check en_pwm=1 with en_out=0 stays 0.
//   6. period_start: pulses exactly once per 3328 clk, one clk wide,
//      aligned with out reflecting pwm_cnt=0 one clk later.

Source files
------------

// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if
//   Groups the register-side inputs and chip-side outputs of the PWM block.
//   master: register block / testbench side (drives enables and duty, observes outputs)
//   slave : pwm_peripheral side
//   Signals:
//     en_reg_out_7_0, en_reg_out_15_8  output enables for out[7:0] / out[15:8]
//     en_reg_pwm_7_0, en_reg_pwm_15_8  PWM-mode selects for out[7:0] / out[15:8]
//     pwm_duty_cycle                   requested duty, 0x00 = 0 %, 0xFF = 100 %
//     out                              16 registered chip outputs
//     period_start                     one-clk pulse when the PWM counter wraps to 0
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Drives 16 chip outputs from the SPI-written control registers. Each output is
//   forced low, held static high, or follows one shared 8-bit PWM waveform. The duty
//   cycle is shadowed and only reloaded at the period boundary, so a mid-period write
//   never produces a runt pulse.
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of pwm_peripheral_if (enables, duty in; out, period_start out)
//   Parameter:
//     CLK_DIV  clk cycles per PWM count step (period = 256*CLK_DIV clk)
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty_q;
  logic             wrap;
  logic             pwm_level;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      out_d;
  logic [15:0]      out_q;
  logic             period_start_q;

  assign tick   = (div_cnt == DIV_LAST);
  assign wrap   = tick && (pwm_cnt == 8'hFF);
  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // pwm_cnt relies on natural 8-bit overflow for the 255 -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Duty shadow loads on the same edge the counter wraps, so the new duty
  // already governs pwm_cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= wrap;
      if (wrap) begin
        duty_q <= bus.pwm_duty_cycle;
      end
    end
  end

  // 0xFF is special-cased so full duty never dips low at pwm_cnt == 255.
  always_comb begin
    pwm_level = 1'b0;
    if (duty_q == 8'hFF) begin
      pwm_level = 1'b1;
    end else begin
      pwm_level = (pwm_cnt < duty_q);
    end
  end

  // Disabled bits are low; enabled non-PWM bits are static high.
  always_comb begin
    out_d = en_out & (~en_pwm | {16{pwm_level}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
module tb_pwm_peripheral;

  localparam int PER = 3328;  // 13 * 256 clk

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  int high, first_low, ps_cnt, ps_idx, bad, waited, hi_seen;

  pwm_peripheral_if bus_if ();

  pwm_peripheral #(.CLK_DIV(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    bus_if.en_reg_out_7_0  = eo[7:0];
    bus_if.en_reg_out_15_8 = eo[15:8];
    bus_if.en_reg_pwm_7_0  = ep[7:0];
    bus_if.en_reg_pwm_15_8 = ep[15:8];
  endtask

  // Waits for period_start at negedge sampling; waited = budget+1 on timeout.
  task automatic wait_ps(input int budget, output int w, output int hs);
    w  = budget + 1;
    hs = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus_if.out != 16'h0000) hs++;
      if (bus_if.period_start) begin
        w = k;
        break;
      end
    end
  endtask

  // Called at the negedge where period_start is seen; samples 1..PER cover one
  // full period as seen on out. Optionally writes the duty at sample wr_at.
  task automatic measure(input logic [15:0] st, input logic [15:0] pm,
                         input int wr_at, input logic [7:0] wr_val,
                         output int hi, output int fl, output int pc,
                         output int pi, output int bd);
    hi = 0; fl = 0; pc = 0; pi = 0; bd = 0;
    for (int k = 1; k <= PER; k++) begin
      @(negedge clk);
      if (bus_if.out[0]) hi++;
      else if (fl == 0) fl = k;
      if (bus_if.period_start) begin
        pc++;
        pi = k;
      end
      if (bus_if.out !== (st | (pm & {16{bus_if.out[0]}}))) bd++;
      if (k == wr_at) bus_if.pwm_duty_cycle = wr_val;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held with everything enabled
    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    bus_if.pwm_duty_cycle = 8'h80;
    repeat (3) @(negedge clk);
    chk("reset_out", int'(bus_if.out), 0);
    chk("reset_ps", int'(bus_if.period_start), 0);

    // First period after reset runs at duty 0
    rst_n = 1'b1;
    wait_ps(4000, waited, hi_seen);
    chk("first_period_len", waited, PER);
    chk("first_period_out_low", hi_seen, 0);

    // duty 0x80 loaded at the first boundary
    measure(16'h0000, 16'hFFFF, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    chk("d80_high", high, 1664);
    chk("d80_first_low", first_low, 1665);
    chk("d80_ps_cnt", ps_cnt, 1);
    chk("d80_ps_idx", ps_idx, PER);
    chk("d80_uniform", bad, 0);

    // duty 0x00
    bus_if.pwm_duty_cycle = 8'h00;
    measure(16'h0000, 16'hFFFF, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    chk("d00_prev_period_keeps_80", high, 1664);
    measure(16'h0000, 16'hFFFF, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    chk("d00_high", high, 0);
    chk("d00_first_low", first_low, 1);
    chk("d00_ps_idx", ps_idx, PER);

    // duty 0xFF: no low sample anywhere in the period
    bus_if.pwm_duty_cycle = 8'hFF;
    measure(16'h0000, 16'hFFFF, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    measure(16'h0000, 16'hFFFF, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    chk("dFF_high", high, PER);
    chk("dFF_first_low", first_low, 0);
    chk("dFF_uniform", bad, 0);

    // duty 0x01
    bus_if.pwm_duty_cycle = 8'h01;
    measure(16'h0000, 16'hFFFF, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    measure(16'h0000, 16'hFFFF, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    chk("d01_high", high, 13);
    chk("d01_first_low", first_low, 14);
    chk("d01_ps_cnt", ps_cnt, 1);

    // Mid-period write: 0x40 running, 0xC0 written at pwm_cnt = 0x20
    bus_if.pwm_duty_cycle = 8'h40;
    measure(16'h0000, 16'hFFFF, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    measure(16'h0000, 16'hFFFF, 417, 8'hC0, high, first_low, ps_cnt, ps_idx, bad);
    chk("mid_cur_high", high, 832);
    chk("mid_cur_first_low", first_low, 833);
    chk("mid_cur_ps_idx", ps_idx, PER);
    measure(16'h0000, 16'hFFFF, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    chk("mid_next_high", high, 2496);
    chk("mid_next_first_low", first_low, 2497);

    // Static outputs, registered one clk after the write
    set_en(16'hFFFF, 16'h0000);
    #1;
    chk("static_not_yet", int'(bus_if.out[15:1]), 16'h7FFF & {15{bus_if.out[0]}});
    @(negedge clk);
    chk("static_ffff", int'(bus_if.out), 16'hFFFF);
    set_en(16'h00F0, 16'h0000);
    @(negedge clk);
    chk("static_00f0", int'(bus_if.out), 16'h00F0);

    // Mixed mux at duty 0x80
    bus_if.pwm_duty_cycle = 8'h80;
    set_en(16'h0F0F, 16'h0303);
    wait_ps(4000, waited, hi_seen);
    chk("mix_sync_found", int'(waited <= 4000), 1);
    measure(16'h0C0C, 16'h0303, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    chk("mix_high", high, 1664);
    chk("mix_pattern", bad, 0);
    chk("mix_ps_idx", ps_idx, PER);

    // PWM select without output enable stays low
    set_en(16'h0000, 16'hFFFF);
    measure(16'h0000, 16'h0000, 0, 8'h00, high, first_low, ps_cnt, ps_idx, bad);
    chk("pwm_no_en_low", bad, 0);

    // Asynchronous reset mid-period
    set_en(16'hFFFF, 16'h0000);
    @(negedge clk);
    chk("pre_async_out", int'(bus_if.out), 16'hFFFF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", int'(bus_if.out), 0);
    chk("async_reset_ps", int'(bus_if.period_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_static", int'(bus_if.out), 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
